// File: rtl/simple_bus_pkg.sv
// Shared types for the simple command bus target: opcode enum, queue entry and FSM states.
package simple_bus_pkg;

    localparam int CMD_W  = 4;
    localparam int ADDR_W = 16;
    localparam int WAIT_W = 4;

    typedef enum logic [CMD_W-1:0] {
        NOP  = 4'd0,
        LOAD = 4'd1,
        ADD  = 4'd2,
        XOR  = 4'd3,
        CLR  = 4'd4,
        WAIT = 4'd5
    } cmd_e;

    typedef struct packed {
        cmd_e              cmd;
        logic [ADDR_W-1:0] saddr;
    } cmd_entry_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } fsm_state_e;

    // Opcodes 6..15 travel through the queue as raw enum values and are rejected here.
    function automatic logic is_legal(input cmd_e c);
        return (c inside {NOP, LOAD, ADD, XOR, CLR, WAIT});
    endfunction

endpackage

// File: rtl/simple_bus_cmd_fifo.sv
// Command queue: power-of-two ring buffer with an extra count bit to tell full from empty.
module simple_bus_cmd_fifo
    import simple_bus_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          push,
    input  logic          pop,
    input  cmd_entry_t    din,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output cmd_entry_t    head
);

    cmd_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/simple_bus_cmd_target.sv
// Bus target: queues accepted commands and executes them in order on a 16-bit accumulator.
module simple_bus_cmd_target
    import simple_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              en,
    input  logic [CMD_W-1:0]  cmd,
    input  logic [ADDR_W-1:0] saddr,
    input  logic              done,
    output logic              stall,
    output logic [ADDR_W-1:0] acc,
    output logic              busy,
    output logic              seq_done,
    output logic [CNT_W-1:0]  cmd_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fsm_state_e        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [ADDR_W-1:0] acc_nxt;
    logic [CNT_W-1:0]  cmd_count_nxt, err_count_nxt;
    logic              done_pend;
    logic              accept;
    logic              pop;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    cmd_entry_t        push_entry, head;

    assign accept     = en && !stall;
    assign push_entry = '{cmd: cmd_e'(cmd), saddr: saddr};

    simple_bus_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (accept),
        .pop   (pop),
        .din   (push_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (head)
    );

    // Stall comes only from the registered count, so a pop never frees a slot in the same cycle.
    assign stall    = fifo_full;
    assign busy     = (fifo_count != '0) || (state != S_IDLE);
    assign seq_done = done_pend && fifo_empty && (state == S_IDLE) && !accept;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            acc       <= '0;
            cmd_count <= '0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            acc       <= acc_nxt;
            cmd_count <= cmd_count_nxt;
            err_count <= err_count_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        acc_nxt       = acc;
        cmd_count_nxt = cmd_count;
        err_count_nxt = err_count;
        pop           = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (cmd_count != {CNT_W{1'b1}}) cmd_count_nxt = cmd_count + CNT_W'(1);
                    if (!is_legal(head.cmd) && (err_count != {CNT_W{1'b1}}))
                        err_count_nxt = err_count + CNT_W'(1);
                    case (head.cmd)
                        LOAD:    acc_nxt = head.saddr;
                        ADD:     acc_nxt = acc + head.saddr;
                        XOR:     acc_nxt = acc ^ head.saddr;
                        CLR:     acc_nxt = '0;
                        WAIT: begin
                            state_nxt = S_HOLD;
                            wait_nxt  = head.saddr[WAIT_W-1:0];
                        end
                        default: acc_nxt = acc;
                    endcase
                end
            end
            S_HOLD: begin
                if (wait_cnt == '0) state_nxt = S_IDLE;
                else                wait_nxt  = wait_cnt - WAIT_W'(1);
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A done arriving while the pulse fires is merged into that pulse.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)         done_pend <= 1'b0;
        else if (seq_done) done_pend <= 1'b0;
        else if (done)     done_pend <= 1'b1;
    end

endmodule

// File: tb/tb_simple_bus_cmd_target.sv
// Directed self-checking bench for simple_bus_cmd_target with hand-computed expectations.
module tb_simple_bus_cmd_target;

    logic        clk;
    logic        rst_;
    logic        en;
    logic [3:0]  cmd;
    logic [15:0] saddr;
    logic        done;
    logic        stall;
    logic [15:0] acc;
    logic        busy;
    logic        seq_done;
    logic [15:0] cmd_count;
    logic [15:0] err_count;

    int vectors;
    int miscompares;

    logic [3:0]  q_cmd  [8];
    logic [15:0] q_addr [8];
    logic        q_done [8];
    logic [15:0] stall_hist;
    int          drive_cycles;

    simple_bus_cmd_target #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .en        (en),
        .cmd       (cmd),
        .saddr     (saddr),
        .done      (done),
        .stall     (stall),
        .acc       (acc),
        .busy      (busy),
        .seq_done  (seq_done),
        .cmd_count (cmd_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // Master model: holds each command until a cycle where stall is low.
    task automatic drive_cmds(input int n);
        int  idx;
        int  cyc;
        logic accepted;
        idx = 0;
        cyc = 0;
        stall_hist = '0;
        while (idx < n && cyc < 60) begin
            en    = 1'b1;
            cmd   = q_cmd[idx];
            saddr = q_addr[idx];
            done  = q_done[idx];
            #1;
            if (cyc < 16) stall_hist[cyc] = stall;
            accepted = !stall;
            clk1();
            if (accepted) idx++;
            cyc++;
        end
        en   = 1'b0;
        done = 1'b0;
        drive_cycles = cyc;
        vectors++;
        if (idx != n) begin
            $display("[TB] FAIL drive_timeout: accepted %0d commands, required %0d", idx, n);
            miscompares++;
        end
    endtask

    task automatic clear_q();
        for (int i = 0; i < 8; i++) begin
            q_cmd[i]  = 4'd0;
            q_addr[i] = 16'h0;
            q_done[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_ = 1'b0; en = 1'b0; cmd = 4'd0; saddr = 16'h0; done = 1'b0;
        clk1();
        clk1();
        vectors += 6;
        if (acc !== 16'h0)       begin $display("[TB] FAIL reset_acc: got %h want 0000", acc); miscompares++; end
        if (stall !== 1'b0)      begin $display("[TB] FAIL reset_stall: got %b want 0", stall); miscompares++; end
        if (busy !== 1'b0)       begin $display("[TB] FAIL reset_busy: got %b want 0", busy); miscompares++; end
        if (seq_done !== 1'b0)   begin $display("[TB] FAIL reset_seq_done: got %b want 0", seq_done); miscompares++; end
        if (cmd_count !== 16'h0) begin $display("[TB] FAIL reset_cmd_count: got %0d want 0", cmd_count); miscompares++; end
        if (err_count !== 16'h0) begin $display("[TB] FAIL reset_err_count: got %0d want 0", err_count); miscompares++; end
        rst_ = 1'b1;
        clk1();
    endtask

    task automatic test_basic_ops();
        en = 1'b1; cmd = 4'd1; saddr = 16'h1234;
        clk1();
        cmd = 4'd2; saddr = 16'hF000;
        clk1();
        vectors++;
        if (acc !== 16'h1234) begin $display("[TB] FAIL basic_load: got %h want 1234", acc); miscompares++; end
        cmd = 4'd3; saddr = 16'h00FF;
        clk1();
        vectors++;
        if (acc !== 16'h0234) begin $display("[TB] FAIL basic_add: got %h want 0234", acc); miscompares++; end
        en = 1'b0;
        clk1();
        vectors += 4;
        if (acc !== 16'h02CB)     begin $display("[TB] FAIL basic_xor: got %h want 02cb", acc); miscompares++; end
        if (cmd_count !== 16'd3)  begin $display("[TB] FAIL basic_cmd_count: got %0d want 3", cmd_count); miscompares++; end
        if (err_count !== 16'd0)  begin $display("[TB] FAIL basic_err_count: got %0d want 0", err_count); miscompares++; end
        if (busy !== 1'b0)        begin $display("[TB] FAIL basic_busy: got %b want 0", busy); miscompares++; end
    endtask

    task automatic test_wrap_and_illegal();
        en = 1'b1; cmd = 4'd1; saddr = 16'hFFFF;
        clk1();
        cmd = 4'd2; saddr = 16'h0001;
        clk1();
        vectors++;
        if (acc !== 16'hFFFF) begin $display("[TB] FAIL wrap_load: got %h want ffff", acc); miscompares++; end
        cmd = 4'd9; saddr = 16'h5555;
        clk1();
        vectors += 2;
        if (acc !== 16'h0000)    begin $display("[TB] FAIL wrap_add: got %h want 0000", acc); miscompares++; end
        if (err_count !== 16'd0) begin $display("[TB] FAIL wrap_no_err: got %0d want 0", err_count); miscompares++; end
        en = 1'b0;
        clk1();
        vectors += 3;
        if (acc !== 16'h0000)     begin $display("[TB] FAIL illegal_acc: got %h want 0000", acc); miscompares++; end
        if (err_count !== 16'd1)  begin $display("[TB] FAIL illegal_err: got %0d want 1", err_count); miscompares++; end
        if (cmd_count !== 16'd6)  begin $display("[TB] FAIL illegal_cmd_count: got %0d want 6", cmd_count); miscompares++; end
    endtask

    task automatic test_stall();
        clear_q();
        q_cmd[0] = 4'd5; q_addr[0] = 16'h0003;
        for (int i = 1; i < 7; i++) begin
            q_cmd[i]  = 4'd1;
            q_addr[i] = 16'h1000 + 16'(i);
        end
        drive_cmds(7);
        vectors += 3;
        if (stall_hist !== 16'h0060) begin $display("[TB] FAIL stall_pattern: got %h want 0060", stall_hist); miscompares++; end
        if (drive_cycles != 9)       begin $display("[TB] FAIL stall_cycles: got %0d want 9", drive_cycles); miscompares++; end
        if (acc !== 16'h1003)        begin $display("[TB] FAIL stall_order3: got %h want 1003", acc); miscompares++; end
        for (int i = 4; i < 7; i++) begin
            clk1();
            vectors++;
            if (acc !== 16'h1000 + 16'(i)) begin
                $display("[TB] FAIL stall_order%0d: got %h want %h", i, acc, 16'h1000 + 16'(i));
                miscompares++;
            end
        end
        vectors += 2;
        if (cmd_count !== 16'd13) begin $display("[TB] FAIL stall_cmd_count: got %0d want 13", cmd_count); miscompares++; end
        if (busy !== 1'b0)        begin $display("[TB] FAIL stall_busy: got %b want 0", busy); miscompares++; end
    endtask

    task automatic test_full_boundary();
        clear_q();
        q_cmd[0] = 4'd5; q_addr[0] = 16'h0003;
        q_cmd[1] = 4'd5; q_addr[1] = 16'h0002;
        q_cmd[2] = 4'd1; q_addr[2] = 16'hA001;
        q_cmd[3] = 4'd1; q_addr[3] = 16'hB002;
        q_cmd[4] = 4'd1; q_addr[4] = 16'hC003;
        q_cmd[5] = 4'd1; q_addr[5] = 16'hD004;
        q_cmd[6] = 4'd1; q_addr[6] = 16'hE005;
        drive_cmds(7);
        vectors += 3;
        if (stall_hist !== 16'h0760) begin $display("[TB] FAIL full_stall_window: got %h want 0760", stall_hist); miscompares++; end
        if (drive_cycles != 12)      begin $display("[TB] FAIL full_cycles: got %0d want 12", drive_cycles); miscompares++; end
        if (acc !== 16'hB002)        begin $display("[TB] FAIL full_acc_b: got %h want b002", acc); miscompares++; end
        clk1(); clk1(); clk1();
        vectors += 2;
        if (acc !== 16'hE005)     begin $display("[TB] FAIL full_acc_final: got %h want e005", acc); miscompares++; end
        if (cmd_count !== 16'd20) begin $display("[TB] FAIL full_cmd_count: got %0d want 20", cmd_count); miscompares++; end
    endtask

    task automatic test_done();
        en = 1'b1; cmd = 4'd1; saddr = 16'h0011; done = 1'b0;
        clk1();
        saddr = 16'h0022; done = 1'b1;
        clk1();
        en = 1'b0; done = 1'b1;
        #1;
        vectors++;
        if (seq_done !== 1'b0) begin $display("[TB] FAIL done_early: got %b want 0", seq_done); miscompares++; end
        clk1();
        done = 1'b0;
        #1;
        vectors++;
        if (seq_done !== 1'b1) begin $display("[TB] FAIL done_pulse: got %b want 1", seq_done); miscompares++; end
        clk1();
        vectors += 2;
        if (seq_done !== 1'b0) begin $display("[TB] FAIL done_single: got %b want 0", seq_done); miscompares++; end
        if (acc !== 16'h0022)  begin $display("[TB] FAIL done_acc: got %h want 0022", acc); miscompares++; end
        clk1();
        vectors++;
        if (seq_done !== 1'b0) begin $display("[TB] FAIL done_no_repeat: got %b want 0", seq_done); miscompares++; end
        done = 1'b1;
        #1;
        vectors++;
        if (seq_done !== 1'b0) begin $display("[TB] FAIL done_empty_pre: got %b want 0", seq_done); miscompares++; end
        clk1();
        done = 1'b0;
        #1;
        vectors++;
        if (seq_done !== 1'b1) begin $display("[TB] FAIL done_empty_pulse: got %b want 1", seq_done); miscompares++; end
        clk1();
        vectors++;
        if (seq_done !== 1'b0) begin $display("[TB] FAIL done_empty_after: got %b want 0", seq_done); miscompares++; end
    endtask

    task automatic test_reset_mid();
        clear_q();
        q_cmd[0] = 4'd5; q_addr[0] = 16'h000F;
        q_cmd[1] = 4'd1; q_addr[1] = 16'h7001;
        q_cmd[2] = 4'd1; q_addr[2] = 16'h7002;
        q_cmd[3] = 4'd1; q_addr[3] = 16'h7003; q_done[3] = 1'b1;
        drive_cmds(4);
        vectors++;
        if (busy !== 1'b1) begin $display("[TB] FAIL mid_busy: got %b want 1", busy); miscompares++; end
        #2;
        rst_ = 1'b0;
        #1;
        vectors += 6;
        if (acc !== 16'h0)       begin $display("[TB] FAIL mid_rst_acc: got %h want 0000", acc); miscompares++; end
        if (busy !== 1'b0)       begin $display("[TB] FAIL mid_rst_busy: got %b want 0", busy); miscompares++; end
        if (stall !== 1'b0)      begin $display("[TB] FAIL mid_rst_stall: got %b want 0", stall); miscompares++; end
        if (seq_done !== 1'b0)   begin $display("[TB] FAIL mid_rst_seq_done: got %b want 0", seq_done); miscompares++; end
        if (cmd_count !== 16'h0) begin $display("[TB] FAIL mid_rst_cmd_count: got %0d want 0", cmd_count); miscompares++; end
        if (err_count !== 16'h0) begin $display("[TB] FAIL mid_rst_err_count: got %0d want 0", err_count); miscompares++; end
        clk1();
        clk1();
        rst_ = 1'b1;
        #1;
        vectors += 2;
        if (busy !== 1'b0)     begin $display("[TB] FAIL post_rst_busy: got %b want 0", busy); miscompares++; end
        if (seq_done !== 1'b0) begin $display("[TB] FAIL post_rst_stale_done: got %b want 0", seq_done); miscompares++; end
        clk1();
        en = 1'b1; cmd = 4'd1; saddr = 16'h4321;
        clk1();
        en = 1'b0;
        #1;
        vectors++;
        if (seq_done !== 1'b0) begin $display("[TB] FAIL post_rst_pulse1: got %b want 0", seq_done); miscompares++; end
        clk1();
        vectors += 3;
        if (acc !== 16'h4321)    begin $display("[TB] FAIL post_rst_acc: got %h want 4321", acc); miscompares++; end
        if (cmd_count !== 16'd1) begin $display("[TB] FAIL post_rst_cmd_count: got %0d want 1", cmd_count); miscompares++; end
        if (seq_done !== 1'b0)   begin $display("[TB] FAIL post_rst_pulse2: got %b want 0", seq_done); miscompares++; end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_q();
        test_reset();
        test_basic_ops();
        test_wrap_and_illegal();
        test_stall();
        test_full_boundary();
        test_done();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
